// File: rtl/ucode_sequencer_pkg.sv
// Shared microcode definitions: field positions, sequencer states, fixed table addresses.
// The microcode generator script mirrors these values.
package ucode_sequencer_pkg;

    localparam int unsigned UPC_W  = 7;
    localparam int unsigned CTRL_W = 60;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned TBL_W  = 9;

    localparam int unsigned LAST_BIT  = 59;
    localparam int unsigned CBPFX_BIT = 58;
    localparam int unsigned HALT_BIT  = 57;

    localparam logic [UPC_W-1:0] IRQ_ENTRY = 7'h7E;
    localparam logic [OP_W-1:0]  CB_BASE   = 8'hDD;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_EXEC     = 2'd1,
        ST_CB_FETCH = 2'd2,
        ST_HALTED   = 2'd3
    } seq_state_e;

    // One subop word: three sequencing flags on top of raw datapath controls.
    typedef struct packed {
        logic        last;
        logic        cbpfx;
        logic        halt;
        logic [56:0] dp;
    } subop_t;

    // Entry-table row for a CB-page opcode.
    function automatic logic [TBL_W-1:0] cb_index(input logic [OP_W-1:0] op);
        return TBL_W'(CB_BASE) + TBL_W'(op);
    endfunction

endpackage

// File: rtl/ucode_sequencer_if.sv
// Fetch, microcode-store and datapath signals of the sequencer.
// master = the sequencer, slave = fetch/tables/datapath side.
interface ucode_sequencer_if;
    import ucode_sequencer_pkg::*;

    logic              op_valid;
    logic [OP_W-1:0]   op_byte;
    logic              op_ready;
    logic [TBL_W-1:0]  tbl_index;
    logic [UPC_W-1:0]  tbl_entry;
    logic [UPC_W-1:0]  upc;
    logic [CTRL_W-1:0] subop;
    logic [CTRL_W-1:0] ctrl;
    logic              mem_wait;
    logic              irq_pending;
    logic              ime;
    logic              irq_ack;
    logic              halted;

    modport master (
        input  op_valid, op_byte, tbl_entry, subop, mem_wait, irq_pending, ime,
        output op_ready, tbl_index, upc, ctrl, irq_ack, halted
    );

    modport slave (
        output op_valid, op_byte, tbl_entry, subop, mem_wait, irq_pending, ime,
        input  op_ready, tbl_index, upc, ctrl, irq_ack, halted
    );

endinterface

// File: rtl/ucode_sequencer_upc_ctr.sv
// Micro-PC register: load has priority over increment, otherwise hold.
module ucode_sequencer_upc_ctr
    import ucode_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [UPC_W-1:0] load_val,
    input  logic             inc,
    output logic [UPC_W-1:0] upc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upc <= '0;
        end else if (load) begin
            upc <= load_val;
        end else if (inc) begin
            upc <= upc + UPC_W'(1);
        end
    end

endmodule

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: opcode -> entry table -> subop words -> registered control word.
// Handles CB prefix, HALT, memory-wait stalls and interrupt entry at instruction boundaries.
module ucode_sequencer
    import ucode_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    ucode_sequencer_if.master bus
);

    seq_state_e        state_q;
    seq_state_e        state_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic [CTRL_W-1:0] ctrl_d;
    logic              halted_q;
    logic              upc_load;
    logic [UPC_W-1:0]  upc_load_val;
    logic              upc_inc;
    logic              take_irq;
    logic              fetch_open;
    subop_t            word;

    assign word = bus.subop;

    ucode_sequencer_upc_ctr u_upc_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (upc_load),
        .load_val (upc_load_val),
        .inc      (upc_inc),
        .upc      (bus.upc)
    );

    // State, control word and halt flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            ctrl_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            halted_q <= (state_d == ST_HALTED);
        end
    end

    // Next state, next control word and micro-PC commands.
    always_comb begin
        state_d      = state_q;
        ctrl_d       = '0;
        upc_load     = 1'b0;
        upc_load_val = bus.tbl_entry;
        upc_inc      = 1'b0;
        take_irq     = 1'b0;
        fetch_open   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (bus.ime && bus.irq_pending) begin
                    take_irq     = 1'b1;
                    upc_load     = 1'b1;
                    upc_load_val = IRQ_ENTRY;
                    state_d      = ST_EXEC;
                end else begin
                    fetch_open = 1'b1;
                    if (bus.op_valid) begin
                        upc_load = 1'b1;
                        state_d  = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                // A waiting cycle freezes everything; flags are only honoured once it clears.
                if (bus.mem_wait) begin
                    ctrl_d = ctrl_q;
                end else begin
                    ctrl_d = word;
                    if (word.cbpfx) begin
                        state_d = ST_CB_FETCH;
                    end else if (word.halt) begin
                        state_d = ST_HALTED;
                    end else if (word.last) begin
                        state_d = ST_FETCH;
                    end else begin
                        upc_inc = 1'b1;
                    end
                end
            end
            ST_CB_FETCH: begin
                fetch_open = 1'b1;
                if (bus.op_valid) begin
                    upc_load = 1'b1;
                    state_d  = ST_EXEC;
                end
            end
            ST_HALTED: begin
                if (bus.irq_pending) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign bus.tbl_index = (state_q == ST_CB_FETCH) ? cb_index(bus.op_byte)
                                                    : TBL_W'(bus.op_byte);
    assign bus.op_ready  = fetch_open && !rst;
    assign bus.irq_ack   = take_irq && !rst;
    assign bus.ctrl      = ctrl_q;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer with behavioural entry/subop tables.
module tb_ucode_sequencer;
    import ucode_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   wrap_errs = 0;

    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_LAST = 3'b100;
    localparam logic [2:0] F_CB   = 3'b010;
    localparam logic [2:0] F_HALT = 3'b001;

    logic [6:0]  entry_tbl [512];
    logic [59:0] subop_tbl [128];

    ucode_sequencer_if bus ();

    ucode_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.tbl_entry = entry_tbl[bus.tbl_index];
    assign bus.subop     = subop_tbl[bus.upc];

    function automatic logic [59:0] mkw(input logic [2:0] f, input int idx);
        return {f, 57'(idx) | 57'h1_2300_0000};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Running into the top of the subop table without an end marker would wrap upc.
    always @(negedge clk) begin
        if (!rst && bus.upc == 7'h7F && bus.subop[59:57] == 3'b000) begin
            wrap_errs++;
            $display("FAIL upc_wrap: upc 7f carries no sequencing flag");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 512; i++) entry_tbl[i] = 7'h00;
        for (int i = 0; i < 128; i++) subop_tbl[i] = 60'h0;
        entry_tbl[9'h000] = 7'h00;
        entry_tbl[9'h010] = 7'h10;
        entry_tbl[9'h0CB] = 7'h20;
        entry_tbl[9'h114] = 7'h30;
        entry_tbl[9'h076] = 7'h40;
        entry_tbl[9'h005] = 7'h50;
        subop_tbl[7'h00] = mkw(F_LAST, 'h00);
        subop_tbl[7'h10] = mkw(F_NONE, 'h10);
        subop_tbl[7'h11] = mkw(F_NONE, 'h11);
        subop_tbl[7'h12] = mkw(F_LAST, 'h12);
        subop_tbl[7'h20] = mkw(F_CB,   'h20);
        subop_tbl[7'h30] = mkw(F_NONE, 'h30);
        subop_tbl[7'h31] = mkw(F_LAST, 'h31);
        subop_tbl[7'h40] = mkw(F_HALT, 'h40);
        subop_tbl[7'h50] = mkw(F_NONE, 'h50);
        subop_tbl[7'h51] = mkw(F_NONE, 'h51);
        subop_tbl[7'h52] = mkw(F_NONE, 'h52);
        subop_tbl[7'h53] = mkw(F_LAST, 'h53);
        subop_tbl[7'h7E] = mkw(F_NONE, 'h7E);
        subop_tbl[7'h7F] = mkw(F_LAST, 'h7F);

        bus.op_valid    = 1'b0;
        bus.op_byte     = 8'h00;
        bus.mem_wait    = 1'b0;
        bus.irq_pending = 1'b0;
        bus.ime         = 1'b0;

        // Reset state
        tick; tick;
        chk("rst_ctrl", 64'(bus.ctrl), 64'h0);
        chk("rst_upc", 64'(bus.upc), 64'h0);
        chk("rst_op_ready", 64'(bus.op_ready), 64'h0);
        chk("rst_halted", 64'(bus.halted), 64'h0);
        chk("rst_irq_ack", 64'(bus.irq_ack), 64'h0);
        rst = 1'b0;
        #1;

        // Single-subop NOP
        bus.op_valid = 1'b1; bus.op_byte = 8'h00; #1;
        chk("nop_op_ready", 64'(bus.op_ready), 64'h1);
        chk("nop_tbl_index", 64'(bus.tbl_index), 64'h000);
        tick; bus.op_valid = 1'b0; #1;
        chk("nop_exec_op_ready", 64'(bus.op_ready), 64'h0);
        tick;
        chk("nop_ctrl", 64'(bus.ctrl), 64'(mkw(F_LAST, 'h00)));
        chk("nop_op_ready_again", 64'(bus.op_ready), 64'h1);
        tick;
        chk("nop_ctrl_idle", 64'(bus.ctrl), 64'h0);

        // Three subops, memory wait held two cycles while the second word is on ctrl
        bus.op_valid = 1'b1; bus.op_byte = 8'h10;
        tick; bus.op_valid = 1'b0;
        chk("w3_upc0", 64'(bus.upc), 64'h10);
        tick;
        chk("w3_ctrl0", 64'(bus.ctrl), 64'(mkw(F_NONE, 'h10)));
        chk("w3_upc1", 64'(bus.upc), 64'h11);
        tick;
        chk("w3_ctrl1", 64'(bus.ctrl), 64'(mkw(F_NONE, 'h11)));
        chk("w3_upc2", 64'(bus.upc), 64'h12);
        bus.mem_wait = 1'b1;
        tick;
        chk("w3_wait1_ctrl", 64'(bus.ctrl), 64'(mkw(F_NONE, 'h11)));
        chk("w3_wait1_upc", 64'(bus.upc), 64'h12);
        tick;
        chk("w3_wait2_ctrl", 64'(bus.ctrl), 64'(mkw(F_NONE, 'h11)));
        chk("w3_wait2_upc", 64'(bus.upc), 64'h12);
        bus.mem_wait = 1'b0;
        tick;
        chk("w3_ctrl2", 64'(bus.ctrl), 64'(mkw(F_LAST, 'h12)));
        chk("w3_done_op_ready", 64'(bus.op_ready), 64'h1);

        // CB prefix then 0x37; interrupts ignored on the CB page
        bus.ime = 1'b1;
        bus.op_valid = 1'b1; bus.op_byte = 8'hCB;
        tick; bus.op_valid = 1'b0;
        tick;
        chk("cb_pfx_ctrl", 64'(bus.ctrl), 64'(mkw(F_CB, 'h20)));
        bus.irq_pending = 1'b1; #1;
        chk("cb_wait_irq_ack", 64'(bus.irq_ack), 64'h0);
        chk("cb_wait_op_ready", 64'(bus.op_ready), 64'h1);
        tick;
        chk("cb_wait_ctrl", 64'(bus.ctrl), 64'h0);
        bus.op_valid = 1'b1; bus.op_byte = 8'h37; #1;
        chk("cb_tbl_index", 64'(bus.tbl_index), 64'h114);
        chk("cb_accept_irq_ack", 64'(bus.irq_ack), 64'h0);
        tick; bus.op_valid = 1'b0; bus.irq_pending = 1'b0;
        chk("cb_upc", 64'(bus.upc), 64'h30);
        tick;
        chk("cb_ctrl0", 64'(bus.ctrl), 64'(mkw(F_NONE, 'h30)));
        tick;
        chk("cb_ctrl1", 64'(bus.ctrl), 64'(mkw(F_LAST, 'h31)));

        // HALT woken by irq with ime=0: next opcode runs, no interrupt taken
        bus.ime = 1'b0;
        bus.op_valid = 1'b1; bus.op_byte = 8'h76;
        tick; bus.op_valid = 1'b0;
        tick;
        chk("halt_ctrl", 64'(bus.ctrl), 64'(mkw(F_HALT, 'h40)));
        chk("halt_flag", 64'(bus.halted), 64'h1);
        tick;
        chk("halt_ctrl_idle", 64'(bus.ctrl), 64'h0);
        chk("halt_flag_held", 64'(bus.halted), 64'h1);
        bus.irq_pending = 1'b1;
        tick;
        chk("wake0_halted", 64'(bus.halted), 64'h0);
        chk("wake0_irq_ack", 64'(bus.irq_ack), 64'h0);
        bus.op_valid = 1'b1; bus.op_byte = 8'h00; #1;
        chk("wake0_op_ready", 64'(bus.op_ready), 64'h1);
        tick; bus.op_valid = 1'b0; bus.irq_pending = 1'b0;
        chk("wake0_upc", 64'(bus.upc), 64'h00);
        tick;
        chk("wake0_ctrl", 64'(bus.ctrl), 64'(mkw(F_LAST, 'h00)));

        // HALT woken by irq with ime=1: interrupt dispatched
        bus.ime = 1'b1;
        bus.op_valid = 1'b1; bus.op_byte = 8'h76;
        tick; bus.op_valid = 1'b0;
        tick;
        chk("halt1_flag", 64'(bus.halted), 64'h1);
        bus.irq_pending = 1'b1;
        tick;
        chk("wake1_halted", 64'(bus.halted), 64'h0);
        chk("wake1_irq_ack", 64'(bus.irq_ack), 64'h1);
        chk("wake1_op_ready", 64'(bus.op_ready), 64'h0);
        tick; bus.irq_pending = 1'b0;
        chk("wake1_upc", 64'(bus.upc), 64'(IRQ_ENTRY));
        chk("wake1_ack_pulse", 64'(bus.irq_ack), 64'h0);
        tick;
        chk("wake1_ctrl0", 64'(bus.ctrl), 64'(mkw(F_NONE, 'h7E)));
        tick;
        chk("wake1_ctrl1", 64'(bus.ctrl), 64'(mkw(F_LAST, 'h7F)));

        // Opcode and interrupt together: interrupt first, opcode after its LAST
        bus.op_valid = 1'b1; bus.op_byte = 8'h00; bus.irq_pending = 1'b1; #1;
        chk("race_irq_ack", 64'(bus.irq_ack), 64'h1);
        chk("race_op_ready", 64'(bus.op_ready), 64'h0);
        tick; bus.irq_pending = 1'b0;
        chk("race_upc", 64'(bus.upc), 64'h7E);
        chk("race_exec_op_ready", 64'(bus.op_ready), 64'h0);
        tick; tick;
        chk("race_irq_last", 64'(bus.ctrl), 64'(mkw(F_LAST, 'h7F)));
        chk("race_op_ready_back", 64'(bus.op_ready), 64'h1);
        tick; bus.op_valid = 1'b0;
        chk("race_op_upc", 64'(bus.upc), 64'h00);
        tick;
        chk("race_op_ctrl", 64'(bus.ctrl), 64'(mkw(F_LAST, 'h00)));

        // Asynchronous reset in the middle of a four-subop instruction
        bus.op_valid = 1'b1; bus.op_byte = 8'h05;
        tick; bus.op_valid = 1'b0;
        tick; tick;
        chk("pre_rst_ctrl", 64'(bus.ctrl), 64'(mkw(F_NONE, 'h51)));
        #3 rst = 1'b1;
        #1;
        chk("async_rst_ctrl", 64'(bus.ctrl), 64'h0);
        chk("async_rst_upc", 64'(bus.upc), 64'h0);
        chk("async_rst_op_ready", 64'(bus.op_ready), 64'h0);
        tick;
        rst = 1'b0; #1;
        chk("post_rst_op_ready", 64'(bus.op_ready), 64'h1);
        tick;
        chk("post_rst_ctrl_clean", 64'(bus.ctrl), 64'h0);
        bus.op_valid = 1'b1; bus.op_byte = 8'h10;
        tick; bus.op_valid = 1'b0;
        chk("post_rst_upc", 64'(bus.upc), 64'h10);
        tick;
        chk("post_rst_ctrl0", 64'(bus.ctrl), 64'(mkw(F_NONE, 'h10)));
        tick;
        chk("post_rst_ctrl1", 64'(bus.ctrl), 64'(mkw(F_NONE, 'h11)));
        tick;
        chk("post_rst_ctrl2", 64'(bus.ctrl), 64'(mkw(F_LAST, 'h12)));
        tick;
        chk("post_rst_idle", 64'(bus.ctrl), 64'h0);

        chk("no_upc_wrap", 64'(wrap_errs), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
